instr_fetch_responder: RTL and testbench
========================================

INSTR_FETCH_RESPONDER -- requirements
Module: instr_fetch_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h01000000, the byte address of instruction word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, the number of 32-bit words in the backing ROM; AW = clog2(DEPTH_WORDS).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port flush, input, 1, which discards any in-flight fetch.
REQ-006 SHALL have port req_valid, input, 1, a fetch request from the PC side.
REQ-007 SHALL have port req_addr, input, 32, the fetch byte address.
REQ-008 SHALL have port req_ready, output, 1, which accepts the request when high.
REQ-009 SHALL have port mem_rd_en, output, 1, the ROM read strobe.
REQ-010 SHALL have port mem_rd_addr, output, AW, the ROM word index.
REQ-011 SHALL have port mem_rd_data, input, 32, the ROM data, valid exactly one cycle after mem_rd_en.
REQ-012 SHALL have port rsp_valid, output, 1, which flags a response as available.
REQ-013 SHALL have port rsp_ready, input, 1, the consumer's accept signal.
REQ-014 SHALL have port rsp_instr, output, 32, the fetched instruction word.
REQ-015 SHALL have port rsp_fault, output, 1, which flags the response as a fault.
REQ-016 SHALL have port rsp_fault_code, output, 2: 00 none, 01 misaligned, 10 out of range.
REQ-017 SHALL have port fetch_count, output, 32, the number of completed responses, wrapping modulo 2^32.

Function
REQ-018 SHALL implement the FSM states IDLE, READ and RESP, holding at most one outstanding request.
REQ-019 SHALL drive req_ready = 1 only in IDLE with flush = 0.
REQ-020 SHALL define acceptance as req_valid && req_ready; req_addr SHALL be sampled only in the acceptance cycle.
REQ-021 SHALL flag a misaligned request when req_addr[1:0] != 0; misalignment takes priority over range.
REQ-022 SHALL flag out of range when req_addr < BASE_ADDR or (req_addr - BASE_ADDR) >= DEPTH_WORDS*4, computed with 33-bit unsigned arithmetic so that there is no wrap.
REQ-023 SHALL, on acceptance of a valid address, assert mem_rd_en combinationally in the same cycle with mem_rd_addr = (req_addr - BASE_ADDR)[AW+1:2], and go to READ.
REQ-024 SHALL keep mem_rd_en = 0 in every other cycle; mem_rd_addr is don't-care when mem_rd_en = 0.
REQ-025 SHALL, in READ, register mem_rd_data into rsp_instr, set rsp_fault = 0 and rsp_fault_code = 00, and go to RESP.
REQ-026 SHALL, on acceptance of a faulting address, go directly to RESP with rsp_instr = 32'h00000000, rsp_fault = 1 and the fault code; no ROM read occurs.
REQ-027 SHALL produce rsp_valid at cycle N+2 after acceptance in cycle N for a good fetch, and at N+1 for a fault.
REQ-028 SHALL drive rsp_valid = 1 only in RESP, with rsp_instr, rsp_fault and rsp_fault_code held stable until the handshake.
REQ-029 SHALL, on rsp_valid && rsp_ready, go to IDLE and increment fetch_count by 1; fault responses also count.
REQ-030 SHALL NOT accept a new request in the handshake cycle; req_ready rises the following cycle.
REQ-031 SHALL, when flush = 1 in READ or RESP, go to IDLE next cycle; the discarded response is not counted and rsp_valid drops next cycle.
REQ-032 SHALL let flush take priority over a simultaneous rsp handshake: the state goes to IDLE with no count.
REQ-033 SHALL, when flush = 1 in IDLE, accept nothing and leave the state unchanged.
REQ-034 SHALL have fetch_count wrap from 32'hFFFFFFFF to 0.

Reset
REQ-035 SHALL, when rst = 1 at a clock edge, set state IDLE, rsp_valid = 0, rsp_instr = 0, rsp_fault = 0, rsp_fault_code = 00 and fetch_count = 0.
REQ-036 SHALL hold req_ready = 0 and mem_rd_en = 0 while rst is high.
REQ-037 SHALL let rst take priority over flush and all handshakes; a fetch in progress at reset SHALL be abandoned without a response.

Verification
REQ-038 SHALL cover a good fetch: ROM word 0 = 32'h00500093; req 32'h01000000 accepted in cycle 0 -> mem_rd_en=1 with mem_rd_addr=0 in cycle 0; rsp_valid=1 with rsp_instr=32'h00500093, fault=0 in cycle 2; fetch_count=1 after the handshake.
REQ-039 SHALL cover misaligned: req 32'h01000006 -> no mem_rd_en; rsp_valid in cycle 1 with rsp_fault=1, code 01, instr 0.
REQ-040 SHALL cover out of range: req 32'h00FFFFFC -> code 10; req 32'h01001000 with DEPTH_WORDS=1024 -> code 10; req 32'h01000FFC -> good fetch with mem_rd_addr=1023.
REQ-041 SHALL cover backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_instr stable, req_ready=0 throughout; rsp_ready=1 -> handshake, req_ready=1 in the next cycle.
REQ-042 SHALL cover flush: flush in the READ cycle -> no rsp_valid, IDLE next cycle, fetch_count unchanged; flush coinciding with the RESP handshake -> count unchanged.
REQ-043 SHALL cover reset mid-fetch and counter wrap: rst in RESP -> rsp_valid=0 and fetch_count=0 next cycle; fetch_count preloaded via 2^32-1 responses (or forced) -> reads 0 after one more handshake.

Source files
------------

// File: rtl/instr_fetch_responder_if.sv
// Fetch-side bundle for instr_fetch_responder.
//   flush                          - discard any in-flight fetch
//   req_valid/req_addr/req_ready   - fetch request from the PC side
//   mem_rd_en/mem_rd_addr          - ROM read strobe and word index
//   mem_rd_data                    - ROM data, one cycle after mem_rd_en
//   rsp_valid/rsp_ready            - response handshake
//   rsp_instr/rsp_fault/rsp_fault_code - response payload
//   fetch_count                    - completed responses, wraps mod 2^32
// The slave modport is the responder's view; master is the driver/ROM side.
interface instr_fetch_responder_if #(
  parameter int AW = 10
);
  logic          flush;
  logic          req_valid;
  logic [31:0]   req_addr;
  logic          req_ready;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [31:0]   mem_rd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_instr;
  logic          rsp_fault;
  logic [1:0]    rsp_fault_code;
  logic [31:0]   fetch_count;

  modport slave (
    input  flush, req_valid, req_addr, mem_rd_data, rsp_ready,
    output req_ready, mem_rd_en, mem_rd_addr, rsp_valid, rsp_instr,
           rsp_fault, rsp_fault_code, fetch_count
  );

  modport master (
    output flush, req_valid, req_addr, mem_rd_data, rsp_ready,
    input  req_ready, mem_rd_en, mem_rd_addr, rsp_valid, rsp_instr,
           rsp_fault, rsp_fault_code, fetch_count
  );
endinterface

// File: rtl/instr_fetch_responder.sv
// Instruction fetch responder: accepts one fetch at a time, checks the byte
// address for alignment and range, reads the backing ROM (one-cycle latency)
// and returns the word or a fault response.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - instr_fetch_responder_if.slave (request, ROM, response, counter)
module instr_fetch_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h01000000,
  parameter int          DEPTH_WORDS = 1024,
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                    clk,
  input  logic                    rst,
  instr_fetch_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  // Range arithmetic is done on 33 bits so address - base never wraps.
  localparam logic [32:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [32:0] LIMIT_EXT = 33'(DEPTH_WORDS) * 33'd4;

  state_t      state_reg;
  logic        rsp_valid_reg;
  logic [31:0] rsp_instr_reg;
  logic        rsp_fault_reg;
  logic [1:0]  rsp_fault_code_reg;
  logic [31:0] fetch_count_reg;

  logic [32:0] offset;
  logic        below_base;
  logic [1:0]  fault_code_next;
  logic        req_ready_int;
  logic        accept;

  assign offset     = {1'b0, bus.req_addr} - BASE_EXT;
  assign below_base = ({1'b0, bus.req_addr} < BASE_EXT);

  // Misalignment outranks the range check.
  always_comb begin
    fault_code_next = 2'b00;
    if (bus.req_addr[1:0] != 2'b00) begin
      fault_code_next = 2'b01;
    end else if (below_base || (offset >= LIMIT_EXT)) begin
      fault_code_next = 2'b10;
    end
  end

  assign req_ready_int = (state_reg == IDLE) && !bus.flush && !rst;
  assign accept        = bus.req_valid && req_ready_int;

  assign bus.req_ready   = req_ready_int;
  // The ROM read is launched in the acceptance cycle itself so the data
  // lands while the FSM sits in READ.
  assign bus.mem_rd_en   = accept && (fault_code_next == 2'b00);
  assign bus.mem_rd_addr = offset[AW+1:2];

  assign bus.rsp_valid      = rsp_valid_reg;
  assign bus.rsp_instr      = rsp_instr_reg;
  assign bus.rsp_fault      = rsp_fault_reg;
  assign bus.rsp_fault_code = rsp_fault_code_reg;
  assign bus.fetch_count    = fetch_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      rsp_valid_reg      <= 1'b0;
      rsp_instr_reg      <= 32'h0;
      rsp_fault_reg      <= 1'b0;
      rsp_fault_code_reg <= 2'b00;
      fetch_count_reg    <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (fault_code_next != 2'b00) begin
              // Faulting fetches skip the ROM entirely.
              state_reg          <= RESP;
              rsp_valid_reg      <= 1'b1;
              rsp_instr_reg      <= 32'h0;
              rsp_fault_reg      <= 1'b1;
              rsp_fault_code_reg <= fault_code_next;
            end else begin
              state_reg <= READ;
            end
          end
        end
        READ: begin
          if (bus.flush) begin
            state_reg <= IDLE;
          end else begin
            state_reg          <= RESP;
            rsp_valid_reg      <= 1'b1;
            rsp_instr_reg      <= bus.mem_rd_data;
            rsp_fault_reg      <= 1'b0;
            rsp_fault_code_reg <= 2'b00;
          end
        end
        RESP: begin
          // Flush wins over a simultaneous handshake: nothing is counted.
          if (bus.flush) begin
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
          end else if (bus.rsp_ready) begin
            state_reg       <= IDLE;
            rsp_valid_reg   <= 1'b0;
            fetch_count_reg <= fetch_count_reg + 32'd1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          rsp_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_responder.sv
module tb_instr_fetch_responder;

  localparam logic [31:0] BASE  = 32'h01000000;
  localparam int          DEPTH = 1024;

  typedef struct {
    logic [31:0] instr;
    logic        fault;
    logic [1:0]  code;
    int          acc_cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;

  instr_fetch_responder_if #(.AW(10)) bus();

  instr_fetch_responder #(
    .BASE_ADDR  (BASE),
    .DEPTH_WORDS(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  logic [31:0] rom [DEPTH];
  exp_t        sb[$];
  int          total_checks;
  int          fail_checks;
  logic [31:0] exp_count;
  bit          chk_count;
  bit          prev_valid;
  logic [31:0] prev_instr;
  logic        prev_fault;
  logic [1:0]  prev_code;
  exp_t        mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM model: data valid exactly one cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= rom[bus.mem_rd_addr];
    else               bus.mem_rd_data <= $urandom;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total_checks++;
    if (act !== expv) begin
      fail_checks++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // Reference: what a fetch of byte address a must return.
  function automatic exp_t model(input logic [31:0] a, input int c);
    exp_t   m;
    longint off;
    off       = longint'(a) - longint'(BASE);
    m.acc_cyc = c;
    m.instr   = 32'h0;
    m.fault   = 1'b1;
    m.code    = 2'b00;
    if (a % 4 != 0)                         m.code = 2'b01;
    else if (off < 0 || off >= DEPTH * 4)   m.code = 2'b10;
    else begin
      m.fault = 1'b0;
      m.instr = rom[int'(off / 4)];
    end
    return m;
  endfunction

  function automatic int word_index(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  // Monitor / scoreboard checker.
  always @(negedge clk) begin
    if (chk_count) begin
      check("fetch_count", bus.fetch_count, exp_count);
      chk_count = 1'b0;
    end
    if (rst) begin
      check("req_ready_in_rst", 32'(bus.req_ready), 32'd0);
      check("mem_rd_en_in_rst", 32'(bus.mem_rd_en), 32'd0);
      exp_count  = 32'h0;
      chk_count  = 1'b1;
      prev_valid = 1'b0;
    end else begin
      if (bus.req_valid && bus.req_ready) begin
        mon_e = model(bus.req_addr, cyc);
        check("mem_rd_en_on_accept", 32'(bus.mem_rd_en), 32'(!mon_e.fault));
        if (!mon_e.fault)
          check("mem_rd_addr", 32'(bus.mem_rd_addr), 32'(word_index(bus.req_addr)));
      end else begin
        check("mem_rd_en_quiet", 32'(bus.mem_rd_en), 32'd0);
      end
      if (bus.rsp_valid) begin
        check("req_ready_while_rsp", 32'(bus.req_ready), 32'd0);
        if (!prev_valid) begin
          if (sb.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
          else check("rsp_latency", 32'(cyc - sb[0].acc_cyc), sb[0].fault ? 32'd1 : 32'd2);
        end else begin
          check("hold_instr", bus.rsp_instr, prev_instr);
          check("hold_fault", 32'(bus.rsp_fault), 32'(prev_fault));
          check("hold_code", 32'(bus.rsp_fault_code), 32'(prev_code));
        end
        if (bus.rsp_ready && !bus.flush) begin
          if (sb.size() == 0) begin
            check("handshake_no_expect", 32'd1, 32'd0);
          end else begin
            mon_e = sb.pop_front();
            check("rsp_instr", bus.rsp_instr, mon_e.instr);
            check("rsp_fault", 32'(bus.rsp_fault), 32'(mon_e.fault));
            check("rsp_fault_code", 32'(bus.rsp_fault_code), 32'(mon_e.code));
          end
          exp_count = exp_count + 32'd1;
          chk_count = 1'b1;
        end
      end
      prev_valid = bus.rsp_valid;
      prev_instr = bus.rsp_instr;
      prev_fault = bus.rsp_fault;
      prev_code  = bus.rsp_fault_code;
    end
  end

  // Present a request until accepted; optionally record its expected response.
  task automatic issue(input logic [31:0] a, input bit push, output bit ok);
    int n;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    @(negedge clk);
    n = 0;
    while (!bus.req_ready && n < 10) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    ok = bus.req_ready;
    if (!ok) check("req_ready_timeout", 32'd0, 32'd1);
    else if (push) sb.push_back(model(a, cyc));
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    ok = bus.rsp_valid;
    if (!ok) begin
      check("rsp_valid_timeout", 32'd0, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
  endtask

  task automatic fetch(input logic [31:0] a, input int hold);
    bit ok;
    issue(a, 1'b1, ok);
    if (!ok) return;
    wait_valid(ok);
    if (!ok) return;
    @(posedge clk); #1;
    repeat (hold) begin @(posedge clk); #1; end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("rsp_valid_after_hs", 32'(bus.rsp_valid), 32'd0);
    check("req_ready_after_hs", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic flush_read(input logic [31:0] a);
    bit ok;
    issue(a, 1'b0, ok);
    if (!ok) return;
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_read_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("flush_read_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_read_no_rsp", 32'(bus.rsp_valid), 32'd0);
    check("flush_read_idle", 32'(bus.req_ready), 32'd1);
    check("flush_read_count", bus.fetch_count, exp_count);
  endtask

  task automatic flush_resp(input logic [31:0] a);
    bit ok;
    issue(a, 1'b1, ok);
    if (!ok) return;
    wait_valid(ok);
    if (!ok) return;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    bus.flush     = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.flush     = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
    @(negedge clk);
    check("flush_resp_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("flush_resp_count", bus.fetch_count, exp_count);
  endtask

  task automatic reset_resp(input logic [31:0] a);
    bit ok;
    issue(a, 1'b1, ok);
    if (!ok) return;
    wait_valid(ok);
    if (!ok) return;
    @(posedge clk); #1;
    rst           = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = BASE;
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
    @(negedge clk);
    check("rst_resp_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_resp_count", bus.fetch_count, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 6))
      0, 1, 2: a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
      3:       a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd4 + 32'($urandom_range(1, 3));
      4:       a = 32'($urandom_range(0, BASE - 1)) & 32'hFFFF_FFFC;
      5:       a = BASE + 32'h1000 + 32'($urandom_range(0, 1 << 20)) * 32'd4;
      default: begin
        case ($urandom_range(0, 4))
          0:       a = BASE;
          1:       a = BASE + 32'h0FFC;
          2:       a = BASE + 32'h1000;
          3:       a = BASE - 32'd4;
          default: a = 32'hFFFF_FFFC;
        endcase
      end
    endcase
    return a;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    cyc           = 0;
    total_checks  = 0;
    fail_checks   = 0;
    exp_count     = 32'h0;
    chk_count     = 1'b0;
    prev_valid    = 1'b0;
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = BASE;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
    rom[0] = 32'h00500093;

    repeat (3) @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_instr", bus.rsp_instr, 32'd0);
    check("reset_rsp_fault", 32'(bus.rsp_fault), 32'd0);
    check("reset_fault_code", 32'(bus.rsp_fault_code), 32'd0);
    check("reset_fetch_count", bus.fetch_count, 32'd0);
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);

    // Directed cases.
    fetch(BASE, 0);
    fetch(BASE + 32'd6, 0);
    fetch(32'h00FF_FFFC, 0);
    fetch(BASE + 32'h1000, 0);
    fetch(BASE + 32'h0FFC, 0);
    fetch(BASE + 32'h0010, 5);
    fetch(32'hFFFF_FFFC, 1);

    // Flush while idle: nothing may be accepted.
    @(posedge clk); #1;
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = BASE + 32'h20;
    @(negedge clk);
    check("idle_flush_req_ready", 32'(bus.req_ready), 32'd0);
    check("idle_flush_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
    @(posedge clk); #1;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("idle_flush_no_rsp", 32'(bus.rsp_valid), 32'd0);

    flush_read(BASE + 32'h40);
    flush_resp(BASE + 32'h44);
    flush_resp(BASE + 32'h3);
    fetch(BASE + 32'h48, 0);
    reset_resp(BASE + 32'h4C);

    // Randomized traffic.
    for (int i = 0; i < 50; i++) begin
      fetch(rand_addr(), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Counter wrap: preload the count, then complete one more fetch.
    @(posedge clk); #1;
    force dut.fetch_count_reg = 32'hFFFF_FFFF;
    exp_count = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.fetch_count_reg;
    @(negedge clk);
    check("preload_count", bus.fetch_count, 32'hFFFF_FFFF);
    fetch(BASE + 32'h8, 0);
    check("wrapped_count", bus.fetch_count, 32'd0);
    fetch(BASE + 32'h9, 0);
    check("count_after_wrap", bus.fetch_count, 32'd1);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", total_checks - fail_checks, total_checks);
    $finish;
  end

endmodule
